// File: rtl/ql_preio_pkg.sv
// Shared types and constants for the pre-IO serial link receive and transmit paths.
package ql_preio_pkg;

  typedef enum logic [2:0] {
    BREAK  = 3'd0,
    IDLE   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Line cycles per frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction

endpackage

// File: rtl/ql_preio_rx_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module ql_preio_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             accept;

  assign full   = (count == (AW+1)'(DEPTH));
  assign valid  = (count != '0);
  assign pop    = valid & ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign rdata  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ql_preio_rx_deser.sv
// Pre-IO link receiver: samples SOC_IN, frames start/data/parity/stop, queues good words for fabric.
module ql_preio_rx_deser
  import ql_preio_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              FPGA_CLK,
  input  logic              FPGA_RST,
  input  logic              SOC_IN,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_PERR,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic              FRAME_ERR,
  output logic              OVERFLOW,
  input  logic              ERR_CLR,
  output rx_state_t         dbg_state
);

  // Handshake: a word transfers on any cycle with RX_VALID & RX_READY; RX_DATA/RX_PERR hold while RX_VALID & ~RX_READY.

  localparam int BCNT_W = $clog2(frame_len(DATA_W, PARITY_EN));
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
  localparam logic PAR_SENSE = (PARITY_ODD == PAR_ODD);
  localparam logic PAR_USED  = (PARITY_EN != 0);

  rx_state_t         state;
  rx_state_t         state_nx;
  logic              sin_q;
  logic              sin_vld;
  logic [BCNT_W-1:0] bcnt;
  logic [DATA_W-1:0] shreg;
  logic              perr;
  logic              push;
  logic              stop_err;
  logic              drop;
  logic [DATA_W:0]   head;

  // sin_vld keeps BREAK from treating the reset value of sin_q as a genuine idle-high sample.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      sin_q   <= 1'b1;
      sin_vld <= 1'b0;
    end else begin
      sin_q   <= SOC_IN;
      sin_vld <= 1'b1;
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) state <= BREAK;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BREAK:   if (sin_q && sin_vld) state_nx = IDLE;
      IDLE:    if (!sin_q) state_nx = DATA;
      DATA:    if (bcnt == LAST_BIT) state_nx = PAR_USED ? PARITY : STOP;
      PARITY:  state_nx = STOP;
      STOP:    state_nx = sin_q ? IDLE : BREAK;
      default: state_nx = BREAK;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    stop_err = 1'b0;
    if (state == STOP) begin
      push     = sin_q;
      stop_err = ~sin_q;
    end
  end

  // Data arrives LSB first, so shifting in from the top leaves bit 0 at the bottom after DATA_W shifts.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      bcnt  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!sin_q) begin
            bcnt <= '0;
            perr <= 1'b0;
          end
        end
        DATA: begin
          shreg <= {sin_q, shreg[DATA_W-1:1]};
          bcnt  <= bcnt + BCNT_W'(1);
        end
        PARITY:  perr <= (^shreg) ^ sin_q ^ PAR_SENSE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      FRAME_ERR <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      FRAME_ERR <= stop_err | (FRAME_ERR & ~ERR_CLR);
      OVERFLOW  <= drop | (OVERFLOW & ~ERR_CLR);
    end
  end

  ql_preio_rx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (FPGA_CLK),
    .rst   (FPGA_RST),
    .push  (push),
    .wdata ({shreg, perr & PAR_USED}),
    .ready (RX_READY),
    .rdata (head),
    .valid (RX_VALID),
    .drop  (drop)
  );

  assign RX_DATA   = head[DATA_W:1];
  assign RX_PERR   = head[0];
  assign dbg_state = state;

endmodule

// File: tb/tb_ql_preio_rx_deser.sv
// Directed and randomized frames on SOC_IN, checked against a frame-level model of delivered words and flags.
module tb_ql_preio_rx_deser;
  import ql_preio_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       soc_in;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic       err_clr;
  rx_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic       exp_fe;

  ql_preio_rx_deser #(
    .DATA_W     (8),
    .PARITY_EN  (1),
    .PARITY_ODD (PAR_EVEN),
    .FIFO_DEPTH (2)
  ) dut (
    .FPGA_CLK  (clk),
    .FPGA_RST  (rst),
    .SOC_IN    (soc_in),
    .RX_DATA   (rx_data),
    .RX_PERR   (rx_perr),
    .RX_VALID  (rx_valid),
    .RX_READY  (rx_ready),
    .FRAME_ERR (frame_err),
    .OVERFLOW  (overflow),
    .ERR_CLR   (err_clr),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Every word the fabric actually takes, in order.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) obs_q.push_back({rx_data, rx_perr});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic even_bit(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    soc_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pb);
    send_bit(sb);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    send_bit(1'b1);
    err_clr = 1'b0;
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    soc_in   = 1'b1;
    rx_ready = 1'b1;
    err_clr  = 1'b0;
    exp_fe   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_perr", 32'(rx_perr), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_state", 32'(dbg_state), 32'(BREAK));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Good frame: word appears two cycles after the stop bit, for one cycle.
    send_frame(8'hA5, even_bit(8'hA5), 1'b1);
    exp_q.push_back({8'hA5, 1'b0});
    @(negedge clk);
    chk("t1_valid_c1", 32'(rx_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_valid_c2", 32'(rx_valid), 1);
    chk("t1_data", 32'(rx_data), 32'h A5);
    chk("t1_perr", 32'(rx_perr), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_valid_c3", 32'(rx_valid), 0);
    idle(2);
    check_q("t1");

    // Wrong parity bit: still delivered, tagged.
    send_frame(8'h3C, 1'b1, 1'b1);
    exp_q.push_back({8'h3C, 1'b1});
    idle(3);
    chk("t2_frame_err", 32'(frame_err), 0);
    check_q("t2");

    // Bad stop, long low run, one high sample, then a good frame.
    send_frame(8'h55, even_bit(8'h55), 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_frame(8'h01, even_bit(8'h01), 1'b1);
    exp_q.push_back({8'h01, 1'b0});
    idle(3);
    chk("t3_frame_err", 32'(frame_err), 1);
    check_q("t3");
    pulse_clr();
    @(negedge clk);
    chk("t3_frame_err_clr", 32'(frame_err), 0);

    // Back-to-back frames into a stalled FIFO: third word dropped.
    rx_ready = 1'b0;
    send_frame(8'h11, even_bit(8'h11), 1'b1);
    send_frame(8'h22, even_bit(8'h22), 1'b1);
    send_frame(8'h33, even_bit(8'h33), 1'b1);
    idle(2);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_valid_stalled", 32'(rx_valid), 1);
    chk("t4_head_stalled", 32'(rx_data), 32'h11);
    exp_q.push_back({8'h11, 1'b0});
    exp_q.push_back({8'h22, 1'b0});
    rx_ready = 1'b1;
    idle(4);
    chk("t4_valid_drained", 32'(rx_valid), 0);
    check_q("t4");
    pulse_clr();
    @(negedge clk);
    chk("t4_overflow_clr", 32'(overflow), 0);

    // Full FIFO but a pop in the push cycle: word accepted.
    rx_ready = 1'b0;
    send_frame(8'h66, even_bit(8'h66), 1'b1);
    send_frame(8'h77, even_bit(8'h77), 1'b1);
    idle(2);
    chk("t5_valid_full", 32'(rx_valid), 1);
    send_frame(8'h44, even_bit(8'h44), 1'b1);
    rx_ready = 1'b1;
    idle(5);
    chk("t5_overflow", 32'(overflow), 0);
    exp_q.push_back({8'h66, 1'b0});
    exp_q.push_back({8'h77, 1'b0});
    exp_q.push_back({8'h44, 1'b0});
    check_q("t5");

    // Reset during data bit 3 with the line held low past release.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    soc_in = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(rx_valid), 0);
    chk("t6_frame_err_after_rst", 32'(frame_err), 0);
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    idle(3);
    chk("t6_valid_after_low", 32'(rx_valid), 0);
    check_q("t6_no_word");
    send_frame(8'h5A, even_bit(8'h5A), 1'b0);
    pulse_clr();
    @(negedge clk);
    chk("t6_set_beats_clr", 32'(frame_err), 1);
    idle(2);
    pulse_clr();
    @(negedge clk);
    chk("t6_frame_err_clr", 32'(frame_err), 0);
    idle(2);

    // Random frames: random data, parity right or wrong, occasional bad stop, random gaps.
    exp_fe = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       pb;
      logic       sb;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      pb  = ($urandom_range(0, 3) != 0) ? even_bit(d) : ~even_bit(d);
      sb  = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 2);
      if (!sb && gap == 0) gap = 1;
      send_frame(d, pb, sb);
      if (sb) exp_q.push_back({d, pb ^ even_bit(d)});
      else    exp_fe = 1'b1;
      idle(gap);
    end
    idle(4);
    chk("rnd_frame_err", 32'(frame_err), 32'(exp_fe));
    chk("rnd_overflow", 32'(overflow), 0);
    check_q("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
